// File: rtl/h_bridge_gate_driver_pkg.sv
// Shared definitions for the H-bridge gate driver: FSM state and direction encodings
// plus the default timing constants common with the upstream PWM stage.
package h_bridge_gate_driver_pkg;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_CW      = 3'd1,
        S_CCW     = 3'd2,
        S_REVERSE = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_OFF     = 2'd0,
        DIR_CW      = 2'd1,
        DIR_CCW     = 2'd2,
        DIR_REVERSE = 2'd3
    } direction_t;

    localparam int c_Pwm_Period_Clks      = 3333333;
    localparam int c_Default_Dead_Clks    = 50;
    localparam int c_Default_Reverse_Clks = 250000;
    localparam int c_Default_Idle_Clks    = 3400000;
    localparam int c_Default_Cnt_Width    = 24;

    // A fault reports "off" on the direction lines; o_Fault carries the fault itself.
    function automatic direction_t direction_of(input state_t s);
        case (s)
            S_CW:      return DIR_CW;
            S_CCW:     return DIR_CCW;
            S_REVERSE: return DIR_REVERSE;
            default:   return DIR_OFF;
        endcase
    endfunction

endpackage

// File: rtl/h_bridge_gate_driver_if.sv
// Direction requests into, and gate drives/status out of, the H-bridge gate driver.
interface h_bridge_gate_driver_if;

    logic       i_Clockwise;
    logic       i_Counterclockwise;
    logic       o_High_A;
    logic       o_Low_A;
    logic       o_High_B;
    logic       o_Low_B;
    logic [1:0] o_Direction;
    logic       o_Fault;

    modport master (
        output i_Clockwise, i_Counterclockwise,
        input  o_High_A, o_Low_A, o_High_B, o_Low_B, o_Direction, o_Fault
    );

    modport slave (
        input  i_Clockwise, i_Counterclockwise,
        output o_High_A, o_Low_A, o_High_B, o_Low_B, o_Direction, o_Fault
    );

endinterface

// File: rtl/h_bridge_gate_driver_dead_time_leg.sv
// One half-bridge leg: inserts a dead period on enable and on every pwm change,
// so the high and low switches are never on together.
module dead_time_leg #(
    parameter int c_Dead_Clks = 50,
    parameter int c_Cnt_Width = 24
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Enable,
    input  logic i_Pwm,
    output logic o_High,
    output logic o_Low
);

    localparam logic [c_Cnt_Width-1:0] c_Dead_Last = c_Cnt_Width'(c_Dead_Clks - 1);
    localparam logic [c_Cnt_Width-1:0] c_One       = c_Cnt_Width'(1);

    logic                   enabled_q;
    logic                   inDead_q;
    logic                   pwmLast_q;
    logic                   high_q;
    logic                   low_q;
    logic [c_Cnt_Width-1:0] deadCnt_q;

    // A pwm change during the dead period restarts it, which absorbs short pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            enabled_q <= 1'b0;
            inDead_q  <= 1'b0;
            pwmLast_q <= 1'b0;
            high_q    <= 1'b0;
            low_q     <= 1'b0;
            deadCnt_q <= '0;
        end else if (!i_Enable) begin
            enabled_q <= 1'b0;
            inDead_q  <= 1'b0;
            deadCnt_q <= '0;
            high_q    <= 1'b0;
            low_q     <= 1'b0;
        end else if (!enabled_q || (i_Pwm != pwmLast_q)) begin
            enabled_q <= 1'b1;
            inDead_q  <= 1'b1;
            deadCnt_q <= '0;
            pwmLast_q <= i_Pwm;
            high_q    <= 1'b0;
            low_q     <= 1'b0;
        end else if (inDead_q) begin
            if (deadCnt_q == c_Dead_Last) begin
                inDead_q <= 1'b0;
                high_q   <= i_Pwm;
                low_q    <= ~i_Pwm;
            end else begin
                deadCnt_q <= deadCnt_q + c_One;
            end
        end else begin
            high_q <= i_Pwm;
            low_q  <= ~i_Pwm;
        end
    end

    assign o_High = high_q;
    assign o_Low  = low_q;

endmodule

// File: rtl/h_bridge_gate_driver.sv
// H-bridge gate driver: direction FSM with reversal blanking, idle release detection
// and shoot-through lockout, feeding two dead-time legs.
module h_bridge_gate_driver
    import h_bridge_gate_driver_pkg::*;
#(
    parameter int c_Dead_Clks    = c_Default_Dead_Clks,
    parameter int c_Reverse_Clks = c_Default_Reverse_Clks,
    parameter int c_Idle_Clks    = c_Default_Idle_Clks,
    parameter int c_Cnt_Width    = c_Default_Cnt_Width
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    h_bridge_gate_driver_if.slave  bus
);

    localparam logic [c_Cnt_Width-1:0] c_Idle_Last = c_Cnt_Width'(c_Idle_Clks - 1);
    localparam logic [c_Cnt_Width-1:0] c_Rev_Last  = c_Cnt_Width'(c_Reverse_Clks - 1);
    localparam logic [c_Cnt_Width-1:0] c_One       = c_Cnt_Width'(1);

    logic rCw_q, rCcw_q, cwDly_q, ccwDly_q;
    logic cwRise, ccwRise;

    state_t                 state_q, state_d;
    state_t                 target_q, target_d;
    logic [c_Cnt_Width-1:0] idleCnt_q, idleCnt_d;
    logic [c_Cnt_Width-1:0] revCnt_q, revCnt_d;
    logic                   enA_q, enA_d, pwmA_q, pwmA_d;
    logic                   enB_q, enB_d, pwmB_q, pwmB_d;
    direction_t             dir_q, dir_d;
    logic                   fault_q, fault_d;

    logic highA, lowA, highB, lowB;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rCw_q    <= 1'b0;
            rCcw_q   <= 1'b0;
            cwDly_q  <= 1'b0;
            ccwDly_q <= 1'b0;
        end else begin
            rCw_q    <= bus.i_Clockwise;
            rCcw_q   <= bus.i_Counterclockwise;
            cwDly_q  <= rCw_q;
            ccwDly_q <= rCcw_q;
        end
    end

    assign cwRise  = rCw_q & ~cwDly_q;
    assign ccwRise = rCcw_q & ~ccwDly_q;

    // Both requests high at once overrides every other transition.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        idleCnt_d = idleCnt_q;
        revCnt_d  = revCnt_q;
        if (rCw_q && rCcw_q) begin
            state_d   = S_FAULT;
            idleCnt_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    idleCnt_d = '0;
                    revCnt_d  = '0;
                    if (cwRise)       state_d = S_CW;
                    else if (ccwRise) state_d = S_CCW;
                end
                S_CW: begin
                    if (ccwRise) begin
                        state_d  = S_REVERSE;
                        target_d = S_CCW;
                        revCnt_d = '0;
                    end else if (rCw_q) begin
                        idleCnt_d = '0;
                    end else if (idleCnt_q == c_Idle_Last) begin
                        state_d   = S_OFF;
                        idleCnt_d = '0;
                    end else begin
                        idleCnt_d = idleCnt_q + c_One;
                    end
                end
                S_CCW: begin
                    if (cwRise) begin
                        state_d  = S_REVERSE;
                        target_d = S_CW;
                        revCnt_d = '0;
                    end else if (rCcw_q) begin
                        idleCnt_d = '0;
                    end else if (idleCnt_q == c_Idle_Last) begin
                        state_d   = S_OFF;
                        idleCnt_d = '0;
                    end else begin
                        idleCnt_d = idleCnt_q + c_One;
                    end
                end
                S_REVERSE: begin
                    if (cwRise)       target_d = S_CW;
                    else if (ccwRise) target_d = S_CCW;
                    if (revCnt_q == c_Rev_Last) begin
                        state_d   = target_d;
                        revCnt_d  = '0;
                        idleCnt_d = '0;
                    end else begin
                        revCnt_d = revCnt_q + c_One;
                    end
                end
                S_FAULT: begin
                    if (rCw_q || rCcw_q) begin
                        idleCnt_d = '0;
                    end else if (idleCnt_q == c_Idle_Last) begin
                        state_d   = S_OFF;
                        idleCnt_d = '0;
                    end else begin
                        idleCnt_d = idleCnt_q + c_One;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end

        enA_d  = 1'b0;
        pwmA_d = 1'b0;
        enB_d  = 1'b0;
        pwmB_d = 1'b0;
        case (state_d)
            S_CW: begin
                enA_d  = 1'b1;
                pwmA_d = rCw_q;
                enB_d  = 1'b1;
            end
            S_CCW: begin
                enA_d  = 1'b1;
                enB_d  = 1'b1;
                pwmB_d = rCcw_q;
            end
            default: ;
        endcase
        dir_d   = direction_of(state_d);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_OFF;
            target_q  <= S_OFF;
            idleCnt_q <= '0;
            revCnt_q  <= '0;
            enA_q     <= 1'b0;
            pwmA_q    <= 1'b0;
            enB_q     <= 1'b0;
            pwmB_q    <= 1'b0;
            dir_q     <= DIR_OFF;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            idleCnt_q <= idleCnt_d;
            revCnt_q  <= revCnt_d;
            enA_q     <= enA_d;
            pwmA_q    <= pwmA_d;
            enB_q     <= enB_d;
            pwmB_q    <= pwmB_d;
            dir_q     <= dir_d;
            fault_q   <= fault_d;
        end
    end

    dead_time_leg #(.c_Dead_Clks(c_Dead_Clks), .c_Cnt_Width(c_Cnt_Width)) legA (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (enA_q),
        .i_Pwm    (pwmA_q),
        .o_High   (highA),
        .o_Low    (lowA)
    );

    dead_time_leg #(.c_Dead_Clks(c_Dead_Clks), .c_Cnt_Width(c_Cnt_Width)) legB (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (enB_q),
        .i_Pwm    (pwmB_q),
        .o_High   (highB),
        .o_Low    (lowB)
    );

    assign bus.o_High_A    = highA;
    assign bus.o_Low_A     = lowA;
    assign bus.o_High_B    = highB;
    assign bus.o_Low_B     = lowB;
    assign bus.o_Direction = dir_q;
    assign bus.o_Fault     = fault_q;

endmodule

// File: tb/tb_h_bridge_gate_driver.sv
// Directed bench for h_bridge_gate_driver with dead 4, reverse 20, idle 50 clocks.
module tb_h_bridge_gate_driver;
    import h_bridge_gate_driver_pkg::*;

    typedef struct packed {
        logic       cw;
        logic       ccw;
        logic [7:0] cycles;
        logic [3:0] gates;
        logic [1:0] dir;
        logic       fault;
    } vector_t;

    logic    clock = 1'b0;
    logic    resetN;
    int      vectorCount;
    int      miscompareCount;
    vector_t vecs[$];

    always #5 clock = ~clock;

    h_bridge_gate_driver_if bus();

    h_bridge_gate_driver #(
        .c_Dead_Clks    (4),
        .c_Reverse_Clks (20),
        .c_Idle_Clks    (50),
        .c_Cnt_Width    (24)
    ) dut (
        .i_Clk   (clock),
        .i_Rst_L (resetN),
        .bus     (bus)
    );

    // Gate pairs of a leg must never conduct together, whatever else is happening.
    always @(negedge clock) begin
        vectorCount++;
        if ((bus.o_High_A & bus.o_Low_A) | (bus.o_High_B & bus.o_Low_B)) begin
            miscompareCount++;
            $display("[TB] FAIL shoot_through at %0t: got A=%b%b B=%b%b, required no leg with both high", $time,
                     bus.o_High_A, bus.o_Low_A, bus.o_High_B, bus.o_Low_B);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic cw, input logic ccw, input int cycles);
        bus.i_Clockwise        = cw;
        bus.i_Counterclockwise = ccw;
        repeat (cycles) tick();
    endtask

    // gates are packed as {High_A, Low_A, High_B, Low_B}
    task automatic checkOutput(input string name, input logic [3:0] gates, input logic [1:0] dir, input logic fault);
        logic [6:0] actVal;
        logic [6:0] expVal;
        actVal = {bus.o_High_A, bus.o_Low_A, bus.o_High_B, bus.o_Low_B, bus.o_Direction, bus.o_Fault};
        expVal = {gates, dir, fault};
        vectorCount++;
        if (actVal !== expVal) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got gates=%b dir=%0d fault=%b, required gates=%b dir=%0d fault=%b",
                     name, actVal[6:3], actVal[2:1], actVal[0], gates, dir, fault);
        end
    endtask

    task automatic addVec(input logic cw, input logic ccw, input int cycles,
                          input logic [3:0] gates, input logic [1:0] dir, input logic fault);
        vecs.push_back('{cw, ccw, 8'(cycles), gates, dir, fault});
    endtask

    task automatic runTable(input string tag);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cw, vecs[i].ccw, int'(vecs[i].cycles));
            checkOutput($sformatf("%s[%0d]", tag, i), vecs[i].gates, vecs[i].dir, vecs[i].fault);
        end
        vecs.delete();
    endtask

    initial begin
        vectorCount            = 0;
        miscompareCount        = 0;
        resetN                 = 1'b0;
        bus.i_Clockwise        = 1'b0;
        bus.i_Counterclockwise = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i[0], i[1], 1);
            checkOutput($sformatf("reset_hold%0d", i), 4'b0000, DIR_OFF, 1'b0);
        end
        bus.i_Clockwise        = 1'b0;
        bus.i_Counterclockwise = 1'b0;
        resetN                 = 1'b1;

        // CW entry, then 30 high / 10 low PWM with 4-cycle dead gaps on leg A
        addVec(0, 0, 3,  4'b0000, DIR_OFF, 0);
        addVec(1, 0, 2,  4'b0000, DIR_CW,  0);
        addVec(1, 0, 4,  4'b0000, DIR_CW,  0);
        addVec(1, 0, 1,  4'b1001, DIR_CW,  0);
        addVec(1, 0, 23, 4'b1001, DIR_CW,  0);
        addVec(0, 0, 3,  4'b0001, DIR_CW,  0);
        addVec(0, 0, 3,  4'b0001, DIR_CW,  0);
        addVec(0, 0, 1,  4'b0101, DIR_CW,  0);
        addVec(0, 0, 3,  4'b0101, DIR_CW,  0);
        addVec(1, 0, 3,  4'b0001, DIR_CW,  0);
        addVec(1, 0, 4,  4'b1001, DIR_CW,  0);
        addVec(1, 0, 23, 4'b1001, DIR_CW,  0);
        addVec(0, 0, 7,  4'b0101, DIR_CW,  0);
        addVec(0, 0, 3,  4'b0101, DIR_CW,  0);
        runTable("cw_pwm");

        // two-clock pulse in the low phase restarts the dead period twice and is absorbed
        applyStimulus(1, 0, 2);
        checkOutput("pulse_pre", 4'b0101, DIR_CW, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 1);
            checkOutput($sformatf("pulse_dead%0d", k), 4'b0001, DIR_CW, 1'b0);
        end
        applyStimulus(0, 0, 1);
        checkOutput("pulse_recover", 4'b0101, DIR_CW, 1'b0);
        applyStimulus(1, 0, 10);
        checkOutput("pulse_rearm", 4'b1001, DIR_CW, 1'b0);

        // 49 low clocks then high keeps CW; 50 low clocks releases to OFF
        applyStimulus(0, 0, 49);
        checkOutput("idle49_low", 4'b0101, DIR_CW, 1'b0);
        applyStimulus(1, 0, 2);
        checkOutput("idle49_edge", 4'b0101, DIR_CW, 1'b0);
        applyStimulus(1, 0, 10);
        checkOutput("idle49_kept", 4'b1001, DIR_CW, 1'b0);
        applyStimulus(0, 0, 50);
        checkOutput("idle50_last", 4'b0101, DIR_CW, 1'b0);
        applyStimulus(0, 0, 1);
        checkOutput("idle50_off", 4'b0101, DIR_OFF, 1'b0);
        applyStimulus(0, 0, 1);
        checkOutput("idle50_gates", 4'b0000, DIR_OFF, 1'b0);

        // reversal to CCW, then shoot-through request and its idle-based recovery
        addVec(1, 0, 2,  4'b0000, DIR_CW,      0);
        addVec(1, 0, 8,  4'b1001, DIR_CW,      0);
        addVec(0, 1, 2,  4'b1001, DIR_REVERSE, 0);
        addVec(0, 1, 1,  4'b0000, DIR_REVERSE, 0);
        addVec(0, 1, 18, 4'b0000, DIR_REVERSE, 0);
        addVec(0, 1, 1,  4'b0000, DIR_CCW,     0);
        addVec(0, 1, 4,  4'b0000, DIR_CCW,     0);
        addVec(0, 1, 1,  4'b0110, DIR_CCW,     0);
        addVec(0, 0, 7,  4'b0101, DIR_CCW,     0);
        addVec(1, 1, 1,  4'b0101, DIR_CCW,     0);
        addVec(1, 1, 1,  4'b0101, DIR_OFF,     1);
        addVec(1, 1, 1,  4'b0000, DIR_OFF,     1);
        addVec(1, 1, 3,  4'b0000, DIR_OFF,     1);
        addVec(0, 0, 49, 4'b0000, DIR_OFF,     1);
        addVec(0, 0, 1,  4'b0000, DIR_OFF,     1);
        addVec(0, 0, 1,  4'b0000, DIR_OFF,     0);
        runTable("rev_fault");

        // asynchronous reset during a dead period and during steady drive
        applyStimulus(1, 0, 4);
        checkOutput("rst_dead_pre", 4'b0000, DIR_CW, 1'b0);
        resetN = 1'b0;
        #1;
        checkOutput("rst_dead_async", 4'b0000, DIR_OFF, 1'b0);
        applyStimulus(0, 0, 2);
        resetN = 1'b1;
        applyStimulus(0, 0, 5);
        checkOutput("rst_release_off", 4'b0000, DIR_OFF, 1'b0);
        applyStimulus(1, 0, 10);
        checkOutput("rst_drive_pre", 4'b1001, DIR_CW, 1'b0);
        resetN = 1'b0;
        #1;
        checkOutput("rst_drive_async", 4'b0000, DIR_OFF, 1'b0);
        applyStimulus(0, 0, 2);
        resetN = 1'b1;
        applyStimulus(0, 0, 3);
        checkOutput("rst_drive_after", 4'b0000, DIR_OFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule

// File: doc/h_bridge_gate_driver.md
Name: h_bridge_gate_driver

Overview:
- Sits directly downstream of the DC motor PWM/direction stage.
- Consumes its two PWM-gated direction lines (i_Clockwise, i_Counterclockwise) and produces the four gate drives of a discrete H-bridge.
- Adds per-leg dead time, a forced-off interval on direction reversal, an idle timeout that detects direction release, and a shoot-through fault lockout.

Parameters:
c_Dead_Clks, 50, clocks both switches of a leg are held off around every leg transition
c_Reverse_Clks, 250000, clocks all gates are held off between a direction change and driving the new direction
c_Idle_Clks, 3400000, clocks an active direction input must stay low before it counts as released; must exceed the upstream PWM period (3333333)
c_Cnt_Width, 24, width of all internal counters; must hold the largest of the three counts above

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Clockwise  in  1  PWM-gated clockwise request from the upstream stage
i_Counterclockwise  in  1  PWM-gated counterclockwise request from the upstream stage
o_High_A  out  1  leg A high-side gate
o_Low_A  out  1  leg A low-side gate
o_High_B  out  1  leg B high-side gate
o_Low_B  out  1  leg B low-side gate
o_Direction  out  2  0 = off, 1 = CW, 2 = CCW, 3 = reversing
o_Fault  out  1  shoot-through request detected

Behaviour:
- Reset (async assert, sync release):
  - All gates 0, o_Fault 0, o_Direction 0, FSM in S_OFF, all counters 0.
- Inputs:
  - Both inputs are registered once (r_Cw, r_Ccw). An edge means r_x differs from its one-cycle-delayed copy.
  - All outputs are registered.
- Master FSM states: S_OFF, S_CW, S_CCW, S_REVERSE, S_FAULT.
  - S_OFF:
    - r_Cw rising with r_Ccw low -> S_CW.
    - r_Ccw rising with r_Cw low -> S_CCW.
  - S_CW / S_CCW:
    - Idle counter clears on any high cycle of the active input.
    - Idle counter reaching c_Idle_Clks-1 while the input is low -> S_OFF.
    - Rising edge on the opposite input -> S_REVERSE, with the target direction latched.
  - S_REVERSE:
    - All gates 0.
    - Counts c_Reverse_Clks cycles, then enters the latched target state.
    - A rising edge of the original direction during the wait retargets to it; the count does not restart.
  - S_FAULT:
    - Entered from any state whenever r_Cw and r_Ccw are both 1 in the same cycle. This has priority over every other transition.
    - All gates 0 and o_Fault=1 from the next cycle.
    - Exits to S_OFF only after both inputs have been low for c_Idle_Clks consecutive cycles; o_Fault clears on the same cycle.
- Leg mapping:
  - S_CW: leg A is enabled with pwm=r_Cw; leg B is enabled with pwm=0, so it is held low-side on.
  - S_CCW: leg A is enabled with pwm=0; leg B is enabled with pwm=r_Ccw.
  - All other states: both legs disabled.
- Leg behaviour (per leg):
  - Disabled: High=Low=0 on the next cycle, with no dead time.
  - On enable, and on every change of that leg's pwm while enabled: both switches off for exactly c_Dead_Clks cycles, then High=pwm, Low=~pwm.
  - pwm is resampled at the end of the dead period. A pulse shorter than the dead time is therefore absorbed.
  - Another pwm change during the dead period restarts the dead counter.
  - Invariant: High & Low never both 1, in any state or cycle, including across reset.
- Latency:
  - Input edge at the port -> affected gate off: 3 clocks.
  - Input edge at the port -> new gate on: 3 + c_Dead_Clks clocks.
- Counters:
  - Saturate; none wrap.
  - Compare against parameter-1 in c_Cnt_Width-bit unsigned arithmetic.
- Reset mid-operation: gates drop to 0 asynchronously; after release the block is in S_OFF and waits for a fresh rising edge.

Decomposition:
- Shared package holds:
  - the state encoding (S_OFF..S_FAULT);
  - the o_Direction codes;
  - the default timing constants, shared with the upstream PWM stage's period constant.
- One sub-module, dead_time_leg: i_Clk, i_Rst_L, i_Enable, i_Pwm -> o_High, o_Low, parameterised by c_Dead_Clks. Instantiated twice (legs A and B).

Test Plan (all with c_Dead_Clks=4, c_Reverse_Clks=20, c_Idle_Clks=50):
- Reset held, inputs toggling -> all gates 0, o_Direction=0. Release, i_Clockwise pulsing 30 high / 10 low -> o_Direction=1. Low_B=1 from cycle 3+4. High_A follows the input with 4-cycle gaps in which High_A=Low_A=0.
- i_Clockwise pulse of 2 clocks while in S_CW, low phase -> the pulse is absorbed: High_A never rises, Low_A stays 0 for at least 4 cycles then returns to 1.
- In S_CW, raise i_Counterclockwise (i_Clockwise low) -> o_Direction=3 with all gates 0 for 20 cycles. Then o_Direction=2, with leg B high-side PWM after a 4-cycle dead time.
- i_Clockwise and i_Counterclockwise high in the same cycle -> o_Fault=1 and all gates 0. Both low for 49 cycles: still faulted. Cycle 50: o_Fault=0, o_Direction=0.
- In S_CW, i_Clockwise low for 50 cycles -> S_OFF, all gates 0. Low for 49 cycles and then high -> stays in S_CW.
- Every test, continuous assertion: no cycle with High_A&Low_A or High_B&Low_B. Assert i_Rst_L low mid-dead-time -> gates 0 in the same cycle.
